// File: rtl/aud_recorder.sv
// aud_recorder: captures left-channel I2S samples from an audio codec ADC and
// emits them as sequential memory writes.
//
// Ports:
//   i_bclk       codec bit clock, the only clock (rising edge)
//   i_rst_n      asynchronous active-low reset
//   i_adclrck    codec LR clock (0 = left half-frame, 1 = right half-frame)
//   i_adcdat     codec serial ADC data, MSB first
//   i_start      start / resume request (level, sampled every edge)
//   i_pause      pause request (level, sampled every edge)
//   i_stop       stop request (level, sampled every edge)
//   o_data       most recently captured left sample
//   o_address    memory address for o_data
//   o_valid      one-cycle write strobe qualifying o_data / o_address
//   o_recording  high while actively recording (WAIT_LOW, RECV, STORE)
//   o_done       one-cycle pulse when the last address has been written
//   o_state      debug view of the FSM state register
//
// Write handshake: o_valid is a push-only strobe with no ready. When it is
// high, o_data/o_address form one complete write that the memory must accept
// in that cycle; o_data/o_address are stable whenever o_valid is low.
module aud_recorder #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_adclrck,
  input  logic              i_adcdat,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_valid,
  output logic              o_recording,
  output logic              o_done,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_LOW = 3'd1,
    S_RECV     = 3'd2,
    S_STORE    = 3'd3,
    S_PAUSED   = 3'd4
  } state_t;

  localparam int              CNT_W     = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t              state_q, state_d;
  logic                lrc_q;
  logic [DATA_W-1:0]   shift_q;
  logic [CNT_W-1:0]    bit_cnt;
  logic [ADDR_W-1:0]   next_addr;

  logic lrc_fall;
  logic last_bit;
  logic addr_full;
  logic load_sample;
  logic clr_addr;

  assign lrc_fall  = lrc_q & ~i_adclrck;
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign addr_full = (next_addr == LAST_ADDR);

  // State register
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop overrides everything, pause beats start.
  always_comb begin
    state_d     = state_q;
    load_sample = 1'b0;
    clr_addr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_WAIT_LOW;
          clr_addr = 1'b1;
        end
      end
      S_WAIT_LOW: begin
        // The edge that sees the LR fall carries the I2S delay bit, not data.
        if (i_pause)       state_d = S_PAUSED;
        else if (lrc_fall) state_d = S_RECV;
      end
      S_RECV: begin
        if (i_pause) begin
          state_d = S_PAUSED;
        end else if (last_bit) begin
          state_d     = S_STORE;
          load_sample = 1'b1;
        end
      end
      S_STORE: begin
        // The write is already on the outputs this cycle; a full memory ends
        // the recording even if pause is also requested.
        if (addr_full)    state_d = S_IDLE;
        else if (i_pause) state_d = S_PAUSED;
        else              state_d = S_WAIT_LOW;
      end
      S_PAUSED: begin
        if (i_start) state_d = S_WAIT_LOW;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_stop) begin
      state_d     = S_IDLE;
      load_sample = 1'b0;
      clr_addr    = 1'b0;
    end
  end

  // Datapath: LR edge history, deserialiser, bit counter, address pointer
  // and the output sample/address registers.
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrc_q     <= 1'b0;
      shift_q   <= '0;
      bit_cnt   <= '0;
      next_addr <= '0;
      o_data    <= '0;
      o_address <= '0;
    end else begin
      lrc_q <= i_adclrck;

      if (state_q == S_WAIT_LOW && state_d == S_RECV) begin
        bit_cnt <= '0;
        shift_q <= '0;
      end else if (state_q == S_RECV) begin
        shift_q <= {shift_q[DATA_W-2:0], i_adcdat};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      // Output registers load on the LSB edge so the write appears in STORE.
      if (load_sample) begin
        o_data    <= {shift_q[DATA_W-2:0], i_adcdat};
        o_address <= next_addr;
      end

      if (clr_addr) begin
        next_addr <= '0;
      end else if (state_q == S_STORE && !addr_full) begin
        next_addr <= next_addr + ADDR_W'(1);
      end
    end
  end

  assign o_valid     = (state_q == S_STORE);
  assign o_done      = o_valid & addr_full;
  assign o_recording = (state_q == S_WAIT_LOW) || (state_q == S_RECV) ||
                       (state_q == S_STORE);
  assign o_state     = state_q;

endmodule

// File: doc/aud_recorder.md
AUD_RECORDER -- requirements
Module: aud_recorder

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-002 Parameter ADDR_W SHALL default to 20 and set the width of the sample address.
REQ-003 Parameter DATA_W SHALL default to 16 and set the sample width in bits.
REQ-004 i_bclk  in  1  Codec bit clock, the only clock; all state updates on its rising edge.
REQ-005 i_rst_n  in  1  Asynchronous active-low reset.
REQ-006 i_adclrck  in  1  Codec LR clock: low = left half-frame, high = right half-frame.
REQ-007 i_adcdat  in  1  Codec serial ADC data, MSB first.
REQ-008 i_start  in  1  Start or resume request, level-sampled on each rising i_bclk.
REQ-009 i_pause  in  1  Pause request, level-sampled on each rising i_bclk.
REQ-010 i_stop  in  1  Stop request, level-sampled on each rising i_bclk.
REQ-011 o_data  out  DATA_W  Most recently captured left-channel sample.
REQ-012 o_address  out  ADDR_W  Memory address for o_data.
REQ-013 o_valid  out  1  One-cycle write strobe that qualifies o_data and o_address.
REQ-014 o_recording  out  1  High in WAIT_LOW, RECV and STORE.
REQ-015 o_done  out  1  One-cycle pulse when the last address has been written.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT_LOW, RECV, STORE and PAUSED.
REQ-017 A registered copy lrc_q of i_adclrck SHALL be kept, and a falling edge SHALL be detected as lrc_q=1 and i_adclrck=0.
REQ-018 IDLE with i_start=1 SHALL go to WAIT_LOW with the next-address register cleared to 0.
REQ-019 WAIT_LOW on a falling edge SHALL go to RECV with the bit counter at 0; that edge is the I2S one-bit delay and no data is captured on it.
REQ-020 RECV SHALL shift i_adcdat into the LSB of the shift register on each rising edge and increment the counter; after the DATA_W-th bit it SHALL go to STORE.
REQ-021 STORE SHALL last exactly one cycle and output o_data=shift register, o_address=next-address and o_valid=1, then increment next-address.
REQ-022 After STORE the FSM SHALL return to WAIT_LOW, so the right channel is ignored.
REQ-023 Latency SHALL be o_valid exactly one cycle after the rising edge that captures bit 0 (the LSB).
REQ-024 Full memory: if STORE writes address 2^ADDR_W-1, the FSM SHALL pulse o_done in that same cycle, go to IDLE, and not wrap the address.
REQ-025 i_pause=1 in WAIT_LOW, RECV or STORE SHALL go to PAUSED and discard a partial sample; a sample already in STORE SHALL still be emitted.
REQ-026 PAUSED with i_start=1 SHALL go to WAIT_LOW with next-address preserved.
REQ-027 i_stop=1 in any state SHALL go to IDLE and discard a partial sample; o_data and o_address SHALL hold their values.
REQ-028 Control priority SHALL be stop > pause > start when several are asserted in the same cycle.
REQ-029 i_start in WAIT_LOW, RECV or STORE, and i_pause in IDLE or PAUSED, SHALL be ignored.
REQ-030 o_data and o_address SHALL change only in STORE.
REQ-031 o_valid and o_done SHALL never be high for more than one consecutive cycle.

Reset
REQ-032 On i_rst_n=0 the block SHALL immediately enter IDLE and clear lrc_q, the shift register, the counter and next-address.
REQ-033 On reset, o_data=0, o_address=0, o_valid=0, o_recording=0 and o_done=0.
REQ-034 Reset asserted mid-RECV SHALL discard the sample, and no o_valid SHALL follow the release of reset.

Verification
REQ-035 Start, then one lrc falling edge with serial 16'hA5C3 after the delay bit -> single o_valid with o_data=16'hA5C3 and o_address=0, one cycle after the last bit.
REQ-036 Three consecutive frames with left=16'h0001/16'h8000/16'hFFFF and right=16'h1234 -> o_address 0,1,2 with exactly those left values; 16'h1234 is never output.
REQ-037 i_pause asserted after bit 8 of the second sample, later i_start -> the second sample is discarded, and the next full sample is written at o_address=1.
REQ-038 i_stop and i_pause asserted in the same cycle during RECV -> IDLE with o_recording=0; a subsequent i_start restarts at o_address=0.
REQ-039 ADDR_W=3 with nine frames -> writes at addresses 0..7, o_done together with address 7, the ninth frame is ignored and o_recording=0.
REQ-040 Reset pulsed mid-RECV -> all outputs 0 immediately and no o_valid before the next i_start.
